// File: rtl/ex_stage_seq_ctrl_pkg.sv
// Shared EX-stage control definitions: opcodes, ALU/operand-source codes, FSM states and the control word.
package ex_ctrl_pkg;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_STOP  = 4'b1010;
  localparam logic [3:0] OP_BPZ   = 4'b1101;
  // Shift and ori are identified by the low three bits only.
  localparam logic [2:0] OP3_SHIFT = 3'b011;
  localparam logic [2:0] OP3_ORI   = 3'b111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_NAND  = 3'b011;
  localparam logic [2:0] ALU_SHIFT = 3'b100;

  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_BOFS = 2'b01;
  localparam logic [1:0] SRC_ZIMM = 2'b10;
  localparam logic [1:0] SRC_SIMM = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_EXEC     = 3'd1;
  localparam state_t ST_MEM_WAIT = 3'd2;
  localparam state_t ST_ERR      = 3'd3;
  localparam state_t ST_HALT     = 3'd4;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_Z    = 2'd1,
    BR_NZ   = 2'd2,
    BR_PZ   = 2'd3
  } br_kind_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src;
    logic       flag_write;
    logic       alu_out_wr;
    logic       ir4_load;
    logic       is_load;
    logic       is_store;
    logic       is_stop;
    br_kind_e   br_kind;
  } ctrl_t;

  function automatic logic br_eval(input br_kind_e kind, input logic n, input logic z);
    case (kind)
      BR_Z:    return z;
      BR_NZ:   return !z;
      BR_PZ:   return !n;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_seq_ctrl_if.sv
// IR3 handshake, flag/memory inputs and EX control outputs; slave is the controller, master its environment.
interface ex_stage_seq_ctrl_if #(
  parameter int IR_W    = 8,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic              ir_valid;
  logic [IR_W-1:0]   ir;
  logic              ir_ready;
  logic              flush;
  logic              flag_n;
  logic              flag_z;
  logic              mem_ack;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]        alu_src;
  logic              flag_write;
  logic              alu_out_wr;
  logic              mem_read;
  logic              mem_write;
  logic              mdr_load;
  logic              ir4_load;
  logic              br_taken;
  logic              mem_err;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output ir_valid, ir, flush, flag_n, flag_z, mem_ack,
    input  ir_ready, alu_op, alu_src, flag_write, alu_out_wr, mem_read, mem_write,
           mdr_load, ir4_load, br_taken, mem_err, halted, stall_cnt
  );

  modport slave (
    input  ir_valid, ir, flush, flag_n, flag_z, mem_ack,
    output ir_ready, alu_op, alu_src, flag_write, alu_out_wr, mem_read, mem_write,
           mdr_load, ir4_load, br_taken, mem_err, halted, stall_cnt
  );
endinterface

// File: rtl/ex_stage_seq_ctrl_decode.sv
// Combinational IR3 decode into the EX control word; unlisted opcodes decode to an all-zero NOP.
module ex_decode
  import ex_ctrl_pkg::*;
#(
  parameter int IR_W = 8
) (
  input  logic [IR_W-1:0] ir_i,
  output ctrl_t           cw_o
);

  logic unused_ir_hi;
  assign unused_ir_hi = ^ir_i[IR_W-1:4];

  always_comb begin
    cw_o = '0;
    if (ir_i[2:0] == OP3_SHIFT) begin
      cw_o.alu_op     = ALU_SHIFT;
      cw_o.alu_src    = SRC_SIMM;
      cw_o.flag_write = 1'b1;
      cw_o.alu_out_wr = 1'b1;
      cw_o.ir4_load   = 1'b1;
    end else if (ir_i[2:0] == OP3_ORI) begin
      cw_o.alu_op     = ALU_OR;
      cw_o.alu_src    = SRC_ZIMM;
      cw_o.flag_write = 1'b1;
      cw_o.alu_out_wr = 1'b1;
      cw_o.ir4_load   = 1'b1;
    end else begin
      case (ir_i[3:0])
        OP_ADD, OP_SUB, OP_NAND: begin
          cw_o.alu_op     = (ir_i[3:0] == OP_ADD) ? ALU_ADD :
                            (ir_i[3:0] == OP_SUB) ? ALU_SUB : ALU_NAND;
          cw_o.alu_src    = SRC_REG;
          cw_o.flag_write = 1'b1;
          cw_o.alu_out_wr = 1'b1;
          cw_o.ir4_load   = 1'b1;
        end
        OP_LOAD:  cw_o.is_load  = 1'b1;
        OP_STORE: cw_o.is_store = 1'b1;
        OP_STOP:  cw_o.is_stop  = 1'b1;
        OP_BZ, OP_BNZ, OP_BPZ: begin
          // Branches still move on to IR4; only the target adder operand changes.
          cw_o.alu_src  = SRC_BOFS;
          cw_o.ir4_load = 1'b1;
          cw_o.br_kind  = (ir_i[3:0] == OP_BZ)  ? BR_Z :
                          (ir_i[3:0] == OP_BNZ) ? BR_NZ : BR_PZ;
        end
        default: cw_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_seq_ctrl.sv
// Sequenced EX-stage control: registers the decoded IR3 word, holds the pipe across memory req/ack with timeout,
// resolves branches and halts on STOP. EX_STALL_CNT_EN enables the saturating MEM_WAIT stall counter.
module ex_stage_seq_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int IR_W        = 8,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset,
  ex_stage_seq_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  ctrl_t             cw_q, cw_d;
  ctrl_t             dec_cw;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ready;
  logic              flush_eff;
  logic              accept;

  ex_decode #(.IR_W(IR_W)) u_decode (
    .ir_i (bus.ir),
    .cw_o (dec_cw)
  );

  always_comb begin
    case (state_q)
      ST_IDLE, ST_EXEC: ready = 1'b1;
      ST_MEM_WAIT:      ready = bus.mem_ack;
      default:          ready = 1'b0;
    endcase
  end

  // Flush only has meaning while an instruction could be in or entering EXEC.
  assign flush_eff    = bus.flush && (state_q == ST_IDLE || state_q == ST_EXEC);
  assign accept       = bus.ir_valid && ready && !flush_eff;
  assign bus.ir_ready = ready;

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE, ST_EXEC, ST_ERR: state_d = ST_IDLE;
      ST_MEM_WAIT: begin
        if (bus.mem_ack) begin
          state_d = ST_IDLE;
        end else if (wait_q >= WAIT_MAX) begin
          state_d = ST_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      cw_d   = dec_cw;
      wait_d = WAIT_W'(1);
      if (dec_cw.is_load || dec_cw.is_store) begin
        state_d = ST_MEM_WAIT;
      end else if (dec_cw.is_stop) begin
        state_d = ST_HALT;
      end else begin
        state_d = ST_EXEC;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cw_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    bus.alu_op     = '0;
    bus.alu_src    = '0;
    bus.flag_write = 1'b0;
    bus.alu_out_wr = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mdr_load   = 1'b0;
    bus.ir4_load   = 1'b0;
    bus.br_taken   = 1'b0;
    bus.mem_err    = 1'b0;
    bus.halted     = 1'b0;
    case (state_q)
      ST_EXEC: begin
        if (!bus.flush) begin
          bus.alu_op     = ALUOP_W'(cw_q.alu_op);
          bus.alu_src    = cw_q.alu_src;
          bus.flag_write = cw_q.flag_write;
          bus.alu_out_wr = cw_q.alu_out_wr;
          bus.ir4_load   = cw_q.ir4_load;
          bus.br_taken   = br_eval(cw_q.br_kind, bus.flag_n, bus.flag_z);
        end
      end
      ST_MEM_WAIT: begin
        // Requests stay asserted until the ack cycle or the timeout abort.
        bus.mem_read  = cw_q.is_load;
        bus.mem_write = cw_q.is_store;
        if (bus.mem_ack) begin
          bus.ir4_load = 1'b1;
          bus.mdr_load = cw_q.is_load;
        end
      end
      ST_ERR:  bus.mem_err = 1'b1;
      ST_HALT: bus.halted  = 1'b1;
      default: ;
    endcase
  end

`ifdef EX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_MEM_WAIT && stall_q != {CNT_W{1'b1}}) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_stage_seq_ctrl.sv
// Directed scoreboard bench for ex_stage_seq_ctrl with MEM_TIMEOUT=4.
module tb_ex_stage_seq_ctrl;

  typedef struct packed {
    logic        ir_ready;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src;
    logic        flag_write;
    logic        alu_out_wr;
    logic        mem_read;
    logic        mem_write;
    logic        mdr_load;
    logic        ir4_load;
    logic        br_taken;
    logic        mem_err;
    logic        halted;
    logic [15:0] stall_cnt;
  } obs_t;

`ifdef EX_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  int   tests;
  int   failed;
  int   stall_acc;

  obs_t  exp_q[$];
  obs_t  msk_q[$];
  string nm_q[$];

  ex_stage_seq_ctrl_if #(.IR_W(8), .ALUOP_W(3), .CNT_W(16)) bus ();

  ex_stage_seq_ctrl #(
    .IR_W(8), .ALUOP_W(3), .MEM_TIMEOUT(4), .CNT_W(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] sx();
    return STALL_EN ? 16'(stall_acc) : 16'h0;
  endfunction

  function automatic obs_t o_idle();
    obs_t r;
    r = '0;
    r.ir_ready  = 1'b1;
    r.stall_cnt = sx();
    return r;
  endfunction

  function automatic obs_t o_alu(input logic [2:0] op, input logic [1:0] src);
    obs_t r;
    r = o_idle();
    r.alu_op     = op;
    r.alu_src    = src;
    r.flag_write = 1'b1;
    r.alu_out_wr = 1'b1;
    r.ir4_load   = 1'b1;
    return r;
  endfunction

  function automatic obs_t o_mem(input logic rd, input logic wr, input logic ack);
    obs_t r;
    r = '0;
    r.mem_read  = rd;
    r.mem_write = wr;
    r.ir_ready  = ack;
    r.ir4_load  = ack;
    r.mdr_load  = ack & rd;
    r.stall_cnt = sx();
    return r;
  endfunction

  function automatic obs_t o_br(input logic taken);
    obs_t r;
    r = o_idle();
    r.alu_src  = 2'b01;
    r.br_taken = taken;
    return r;
  endfunction

  function automatic obs_t o_err();
    obs_t r;
    r = '0;
    r.mem_err   = 1'b1;
    r.stall_cnt = sx();
    return r;
  endfunction

  function automatic obs_t o_halt();
    obs_t r;
    r = '0;
    r.halted    = 1'b1;
    r.stall_cnt = sx();
    return r;
  endfunction

  function automatic obs_t m_full();
    obs_t r;
    r = '1;
    return r;
  endfunction

  function automatic obs_t m_br();
    obs_t r;
    r = '1;
    r.alu_op     = '0;
    r.ir4_load   = 1'b0;
    r.flag_write = 1'b0;
    r.alu_out_wr = 1'b0;
    return r;
  endfunction

  function automatic obs_t m_flush();
    obs_t r;
    r = '1;
    r.ir_ready = 1'b0;
    return r;
  endfunction

  task automatic set_in(input logic v, input logic [7:0] i);
    bus.ir_valid = v;
    bus.ir       = i;
    bus.flush    = 1'b0;
    bus.flag_n   = 1'b0;
    bus.flag_z   = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic step(input obs_t e, input obs_t m, input string nm);
    exp_q.push_back(e);
    msk_q.push_back(m);
    nm_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    obs_t  e;
    obs_t  m;
    obs_t  g;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n = nm_q.pop_front();
      g = {bus.ir_ready, bus.alu_op, bus.alu_src, bus.flag_write, bus.alu_out_wr,
           bus.mem_read, bus.mem_write, bus.mdr_load, bus.ir4_load, bus.br_taken,
           bus.mem_err, bus.halted, bus.stall_cnt};
      tests++;
      if (((g ^ e) & m) !== '0) begin
        failed++;
        $display("FAIL %s: got %h expected %h (mask %h)", n, g, e, m);
      end
    end
  end

  initial begin
    tests     = 0;
    failed    = 0;
    stall_acc = 0;
    reset     = 1'b1;
    set_in(1'b0, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    set_in(1'b0, 8'h00);                    step(o_idle(), m_full(), "reset_idle");
    set_in(1'b0, 8'h00); bus.mem_ack = 1'b1; step(o_idle(), m_full(), "ack_in_idle");

    // add, sub, nand back-to-back
    set_in(1'b1, 8'h04); step(o_idle(), m_full(), "acc_add");
    set_in(1'b1, 8'h06); step(o_alu(3'b000, 2'b00), m_full(), "add");
    set_in(1'b1, 8'h08); step(o_alu(3'b001, 2'b00), m_full(), "sub");
    set_in(1'b0, 8'h00); step(o_alu(3'b011, 2'b00), m_full(), "nand");

    // shift, ori, then a NOP opcode
    set_in(1'b1, 8'h13); step(o_idle(), m_full(), "acc_shift");
    set_in(1'b1, 8'h27); step(o_alu(3'b100, 2'b11), m_full(), "shift");
    set_in(1'b1, 8'h0C); step(o_alu(3'b010, 2'b10), m_full(), "ori");
    set_in(1'b0, 8'h00); step(o_idle(), m_full(), "nop_exec");

    // load acked on third wait cycle; flush during the wait is ignored
    set_in(1'b1, 8'h00); step(o_idle(), m_full(), "acc_load");
    set_in(1'b0, 8'h00); step(o_mem(1'b1, 1'b0, 1'b0), m_full(), "ld_w1"); stall_acc++;
    set_in(1'b0, 8'h00); bus.flush = 1'b1;
                         step(o_mem(1'b1, 1'b0, 1'b0), m_full(), "ld_w2_flush"); stall_acc++;
    set_in(1'b0, 8'h00); bus.mem_ack = 1'b1;
                         step(o_mem(1'b1, 1'b0, 1'b1), m_full(), "ld_ack"); stall_acc++;
    set_in(1'b0, 8'h00); step(o_idle(), m_full(), "post_load");

    // store with no ack times out after 4 wait cycles
    set_in(1'b1, 8'h02); step(o_idle(), m_full(), "acc_store");
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 8'h00); step(o_mem(1'b0, 1'b1, 1'b0), m_full(), "st_wait"); stall_acc++;
    end
    set_in(1'b1, 8'h04); step(o_err(), m_full(), "st_err");
    set_in(1'b0, 8'h00); step(o_idle(), m_full(), "post_err");

    // load acked on the last allowed wait cycle, with an add accepted on the ack
    set_in(1'b1, 8'h00); step(o_idle(), m_full(), "acc_load2");
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 8'h00); step(o_mem(1'b1, 1'b0, 1'b0), m_full(), "ld2_wait"); stall_acc++;
    end
    set_in(1'b1, 8'h04); bus.mem_ack = 1'b1;
                         step(o_mem(1'b1, 1'b0, 1'b1), m_full(), "ld2_ack_last"); stall_acc++;
    set_in(1'b0, 8'h00); step(o_alu(3'b000, 2'b00), m_full(), "add_after_ack");

    // branches resolved against flags in their EXEC cycle
    set_in(1'b1, 8'h05); step(o_idle(), m_full(), "acc_bz");
    set_in(1'b1, 8'h09); bus.flag_z = 1'b1; step(o_br(1'b1), m_br(), "bz_z1");
    set_in(1'b1, 8'h0D); bus.flag_z = 1'b1; step(o_br(1'b0), m_br(), "bnz_z1");
    set_in(1'b1, 8'h05); step(o_br(1'b1), m_br(), "bpz_n0");
    set_in(1'b1, 8'h04); bus.flag_z = 1'b1; bus.flush = 1'b1;
                         step('{default: '0, stall_cnt: sx()}, m_flush(), "bz_flush");
    set_in(1'b0, 8'h00); step(o_idle(), m_full(), "post_flush");

    // reset in the middle of a memory wait
    set_in(1'b1, 8'h00); step(o_idle(), m_full(), "acc_load3");
    set_in(1'b0, 8'h00); step(o_mem(1'b1, 1'b0, 1'b0), m_full(), "ld3_w1"); stall_acc++;
    reset = 1'b1;
    set_in(1'b0, 8'h00); step(o_mem(1'b1, 1'b0, 1'b0), m_full(), "ld3_rst_cycle");
    stall_acc = 0;
    reset = 1'b0;
    set_in(1'b0, 8'h00); step(o_idle(), m_full(), "rst_drops_req");

    // stop halts until reset
    set_in(1'b1, 8'h0A); step(o_idle(), m_full(), "acc_stop");
    set_in(1'b1, 8'h04); step(o_halt(), m_full(), "halt1");
    set_in(1'b1, 8'h04); step(o_halt(), m_full(), "halt2");
    reset = 1'b1;
    set_in(1'b1, 8'h04); step(o_halt(), m_full(), "halt_rst_cycle");
    reset = 1'b0;
    set_in(1'b0, 8'h00); step(o_idle(), m_full(), "post_halt_reset");

    @(negedge clock);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
